// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the serial program-load slave (spi_embed_loader).
package spi_loader_pkg;

  localparam int FRAME_ADDR_BITS = 24;
  localparam int FRAME_DATA_BITS = 16;
  localparam int SYNC_DEPTH      = 2;
  localparam int CNT_W           = 5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WE,
    DATA,
    BUS,
    RDOUT
  } loader_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus a registered edge detector.
// Flops reset to the pin's idle level so no spurious edge is seen after reset.
module spi_sync_edge
  import spi_loader_pkg::*;
#(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], i_async};
    prev_d = sync_q[SYNC_DEPTH-1];
    rise_d = sync_q[SYNC_DEPTH-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_DEPTH-1] & prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_DEPTH{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_level = sync_q[SYNC_DEPTH-1];
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/spi_embed_loader.sv
// Serial program-load slave: deserialises LSB-first address/data frames and issues bus writes.
// Optional read-back through miso is enabled with the SPI_LOADER_READ_EN macro.
module spi_embed_loader
  import spi_loader_pkg::*;
#(
  parameter int ADDR_W = FRAME_ADDR_BITS,
  parameter int DATA_W = FRAME_DATA_BITS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  output logic              o_req,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ack,
  input  logic              i_err,
  output logic              o_err
);

  localparam int AIDX_W = $clog2(ADDR_W);
  localparam int DIDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic clk_lvl, clk_rise, clk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sigs;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_clk (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .i_async (i_spi_clk),
    .o_level (clk_lvl),
    .o_rise  (clk_rise),
    .o_fall  (clk_fall)
  );

  // mosi only needs its level; it is stable around the delayed spi_clk rise strobe
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_mosi (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .i_async (i_spi_mosi),
    .o_level (mosi_lvl),
    .o_rise  (mosi_rise),
    .o_fall  (mosi_fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (i_en && clk_rise && !mosi_lvl) begin
          state_d = ADDR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      ADDR: begin
        if (clk_rise) begin
          addr_d[cnt_q[AIDX_W-1:0]] = mosi_lvl;
          if (cnt_q == ADDR_LAST) begin
            state_d = WE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      WE: begin
        if (clk_rise) begin
          we_d = mosi_lvl;
          if (mosi_lvl) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
`ifdef SPI_LOADER_READ_EN
            state_d = BUS;
`else
            state_d = IDLE;
`endif
          end
        end
      end

      DATA: begin
        if (clk_rise) begin
          data_d[cnt_q[DIDX_W-1:0]] = mosi_lvl;
          if (cnt_q == DATA_LAST) begin
            state_d = BUS;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      // spi strobes are ignored here; only the bus response moves us on
      BUS: begin
        if (i_ack || i_err) begin
          err_d   = err_q | i_err;
          state_d = IDLE;
`ifdef SPI_LOADER_READ_EN
          if (!we_q && i_en) begin
            state_d = RDOUT;
            data_d  = i_data;
            cnt_d   = '0;
          end
`endif
        end
      end

`ifdef SPI_LOADER_READ_EN
      RDOUT: begin
        if (clk_fall) begin
          if (cnt_q == DATA_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    if (!i_en && state_q != BUS) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign o_req  = (state_q == BUS);
  assign o_addr = addr_q;
  assign o_data = data_q;
  assign o_err  = err_q;

`ifdef SPI_LOADER_READ_EN
  assign o_we        = we_q;
  assign o_spi_miso  = (state_q == BUS) ||
                       ((state_q == RDOUT) && data_q[cnt_q[DIDX_W-1:0]]);
  assign unused_sigs = ^{clk_lvl, mosi_rise, mosi_fall};
`else
  assign o_we        = 1'b1;
  assign o_spi_miso  = (state_q == BUS);
  assign unused_sigs = ^{i_data, clk_fall, clk_lvl, mosi_rise, mosi_fall, we_q};
`endif

endmodule

// File: tb/tb_spi_embed_loader.sv
// Scoreboard bench for spi_embed_loader: host frames are modelled as expected bus
// transactions and a monitor compares every request the DUT raises.
module tb_spi_embed_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        err;
  logic        err_flag;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic        we;
    bit          chk_data;
    int          width;
  } txn_t;

  txn_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   ack_delay   = 1;
  bit   resp_err    = 1'b0;

  always #5 clk = ~clk;

  spi_embed_loader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_spi_clk  (spi_clk),
    .i_spi_mosi (spi_mosi),
    .o_spi_miso (spi_miso),
    .o_req      (req),
    .o_we       (we),
    .o_addr     (addr),
    .o_data     (wdata),
    .i_data     (rdata),
    .i_ack      (ack),
    .i_err      (err),
    .o_err      (err_flag)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: answers each request after ack_delay cycles with ack or err
  int  rsp_d;
  bit  rsp_e;
  always begin
    @(negedge clk);
    if (rst_n && req) begin
      rsp_d = ack_delay;
      rsp_e = resp_err;
      repeat (rsp_d - 1) @(negedge clk);
      ack = !rsp_e;
      err = rsp_e;
      @(negedge clk);
      ack = 1'b0;
      err = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every new request and measures its length
  txn_t cur;
  logic prev_req = 1'b0;
  int   width    = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (req && !prev_req) begin
        width = 1;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_req: got addr 0x%0h data 0x%0h, expected no request", addr, wdata);
          cur.width = -1;
        end else begin
          cur = exp_q.pop_front();
          checkOutput("req_addr", 32'(addr), 32'(cur.addr));
          checkOutput("req_we", 32'(we), 32'(cur.we));
          if (cur.chk_data) checkOutput("req_data", 32'(wdata), 32'(cur.data));
        end
      end else if (req) begin
        width++;
      end
      if (!req && prev_req && cur.width >= 0) checkOutput("req_width", width, cur.width);
`ifndef SPI_LOADER_READ_EN
      checkOutput("miso_busy", 32'(spi_miso), 32'(req));
`endif
      prev_req = req;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    spi_mosi = b;
    spi_clk  = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [23:0] a, input logic w, input logic [15:0] d);
    send_bit(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("err_clear", 32'(err_flag), 32'd0);
    for (int i = 0; i < 24; i++) send_bit(a[i]);
    send_bit(w);
    if (w) for (int i = 0; i < 16; i++) send_bit(d[i]);
  endtask

  task automatic poll_idle();
    int guard = 0;
    repeat (8) @(negedge clk);
    while (spi_miso && guard < 200) begin
      send_bit(1'b1);
      guard++;
    end
    if (guard >= 200) checkOutput("busy_timeout", 32'(guard), 32'd0);
    send_bit(1'b1);
  endtask

  task automatic applyStimulus(input logic [23:0] a, input logic w, input logic [15:0] d);
    txn_t t;
    bit   exp_err;
    if (w) begin
      t.addr = a; t.data = d; t.we = 1'b1; t.chk_data = 1'b1; t.width = ack_delay;
      exp_q.push_back(t);
    end
    send_frame(a, w, d);
    poll_idle();
    exp_err = w ? resp_err : 1'b0;
    checkOutput("err_flag", 32'(err_flag), 32'(exp_err));
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t;
    int   guard;
    logic [15:0] rd_exp;
    rst_n = 1'b0; en = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b1;
    ack = 1'b0; err = 1'b0; rdata = 16'hA5C3;
    #12;
    checkOutput("rst_req", 32'(req), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_data", 32'(wdata), 32'd0);
    checkOutput("rst_miso", 32'(spi_miso), 32'd0);
    checkOutput("rst_err", 32'(err_flag), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single write, ack after 4 cycles");
    ack_delay = 4;
    applyStimulus(24'h800000, 1'b1, 16'h000E);

    $display("[TB] 40 back-to-back writes");
    ack_delay = 1;
    for (int i = 0; i < 40; i++) applyStimulus(24'h800000 + 24'(i), 1'b1, 16'($urandom));

    $display("[TB] bus error then recovery");
    resp_err = 1'b1;
    applyStimulus(24'h800021, 1'b1, 16'h1234);
    resp_err = 1'b0;
    applyStimulus(24'h800022, 1'b1, 16'h4321);

    $display("[TB] enable dropped mid-address");
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(24'h800030, 1'b1, 16'h0005);

    $display("[TB] randomized frames");
    for (int i = 0; i < 16; i++) begin
      logic w;
      ack_delay = $urandom_range(1, 6);
      resp_err  = ($urandom_range(0, 4) == 0);
`ifdef SPI_LOADER_READ_EN
      w = 1'b1;
`else
      w = ($urandom_range(0, 3) != 0);
`endif
      applyStimulus(24'($urandom), w, 16'($urandom));
    end
    resp_err = 1'b0;

    $display("[TB] reset during bus cycle");
    ack_delay = 30;
    t.addr = 24'h800040; t.data = 16'hBEEF; t.we = 1'b1; t.chk_data = 1'b1; t.width = -1;
    exp_q.push_back(t);
    send_frame(24'h800040, 1'b1, 16'hBEEF);
    guard = 0;
    while (!req && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reset_req_seen", 32'(req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", 32'(req), 32'd0);
    checkOutput("async_rst_miso", 32'(spi_miso), 32'd0);
    checkOutput("async_rst_err", 32'(err_flag), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("late_ack_req", 32'(req), 32'd0);
    ack_delay = 1;

`ifdef SPI_LOADER_READ_EN
    $display("[TB] read frame");
    ack_delay = 2;
    t.addr = 24'h800002; t.data = 16'h0; t.we = 1'b0; t.chk_data = 1'b0; t.width = 2;
    exp_q.push_back(t);
    send_frame(24'h800002, 1'b0, 16'h0);
    guard = 0;
    while (!req && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (req && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("read_req_done", 32'(req), 32'd0);
    rd_exp = 16'hA5C3;
    repeat (2) @(negedge clk);
    checkOutput("read_bit", 32'(spi_miso), 32'(rd_exp[0]));
    for (int i = 1; i < 16; i++) begin
      spi_clk = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("read_bit", 32'(spi_miso), 32'(rd_exp[i]));
      spi_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    send_bit(1'b1);
    repeat (4) @(negedge clk);
    checkOutput("read_done_miso", 32'(spi_miso), 32'd0);
    ack_delay = 1;
`else
    $display("[TB] read frame without read support");
    rd_exp = 16'h0;
    applyStimulus(24'h800002, 1'b0, rd_exp);
`endif

    applyStimulus(24'h800050, 1'b1, 16'hCAFE);
    repeat (10) @(negedge clk);
    checkOutput("pending_txns", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
